// File: rtl/bottle_ctrl_if.sv
// Bottle-filling station control bus.
// Groups the operator buttons, the pill sensor pulse and every controller
// output into one bundle.
//   master : the panel/sensor side, which drives buttons and pill_pulse
//            and observes the controller outputs.
//   slave  : bottle_ctrl, which consumes the buttons and the pill pulse and
//            drives the mode bits, the actuators, the settings and the counts.
// Optional: when BOTTLE_SPILL_CNT_EN is defined the bus also carries
//           spill_cnt.
interface bottle_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             btn_sel;
  logic             btn_inc;
  logic             btn_dec;
  logic             btn_ok;
  logic             btn_start;
  logic             btn_stop;
  logic             pill_pulse;
  logic             EN_work;
  logic             EN_set;
  logic             SET;
  logic             allFull;
  logic             valve_open;
  logic             conveyor_on;
  logic [CNT_W-1:0] pills_per_bottle;
  logic [CNT_W-1:0] bottle_target;
  logic [CNT_W-1:0] pill_cnt;
  logic [CNT_W-1:0] bottle_cnt;
`ifdef BOTTLE_SPILL_CNT_EN
  logic [CNT_W-1:0] spill_cnt;
`endif

  modport master (
`ifdef BOTTLE_SPILL_CNT_EN
    input  spill_cnt,
`endif
    output btn_sel, btn_inc, btn_dec, btn_ok, btn_start, btn_stop, pill_pulse,
    input  EN_work, EN_set, SET, allFull, valve_open, conveyor_on,
    input  pills_per_bottle, bottle_target, pill_cnt, bottle_cnt
  );

  modport slave (
`ifdef BOTTLE_SPILL_CNT_EN
    output spill_cnt,
`endif
    input  btn_sel, btn_inc, btn_dec, btn_ok, btn_start, btn_stop, pill_pulse,
    output EN_work, EN_set, SET, allFull, valve_open, conveyor_on,
    output pills_per_bottle, bottle_target, pill_cnt, bottle_cnt
  );
endinterface

// File: rtl/bottle_ctrl.sv
// bottle_ctrl - master sequencer for the bottle-filling station.
// Runs the operating-mode FSM (CFG / READY / FILL / MOVE / DONE), holds the
// pills-per-bottle and bottle-target settings, counts pills and bottles and
// drives the fill valve and the conveyor. Every output is a register.
// Ports:
//   CLK : system clock, rising edge
//   RST : synchronous, active-high reset
//   bus : bottle_ctrl_if.slave
//           in : btn_sel, btn_inc, btn_dec, btn_ok, btn_start, btn_stop,
//                pill_pulse (all one-cycle pulses)
//           out: EN_work, EN_set, SET, allFull, valve_open, conveyor_on,
//                pills_per_bottle, bottle_target, pill_cnt, bottle_cnt
// Optional: define BOTTLE_SPILL_CNT_EN to add spill_cnt, a saturating count
//           of pills arriving while the valve is closed.
module bottle_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_PILLS   = 50,
  parameter int unsigned MAX_BOTTLES = 99,
  parameter int unsigned CONV_CYCLES = 4
) (
  input logic        CLK,
  input logic        RST,
  bottle_ctrl_if.slave bus
);

  // State codes double as mode bits: [2] = EN_work, [1] = EN_set, so those
  // two outputs come straight off the state register.
  localparam logic [2:0] S_CFG   = 3'b000;
  localparam logic [2:0] S_READY = 3'b010;
  localparam logic [2:0] S_FILL  = 3'b100;
  localparam logic [2:0] S_MOVE  = 3'b101;
  localparam logic [2:0] S_DONE  = 3'b110;

  localparam int unsigned   TMR_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PILL_MAX = CNT_W'(MAX_PILLS);
  localparam logic [CNT_W-1:0] BOT_MAX  = CNT_W'(MAX_BOTTLES);

  logic [2:0]       state_q, state_d;
  logic             set_q, set_d;
  logic             full_q, full_d;
  logic             valve_q, valve_d;
  logic             conv_q, conv_d;
  logic [CNT_W-1:0] ppb_q, ppb_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] pill_q, pill_d;
  logic [CNT_W-1:0] bot_q, bot_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic [CNT_W-1:0] pill_inc;
  logic [CNT_W-1:0] bot_inc;

  assign pill_inc = pill_q + ONE;
  assign bot_inc  = bot_q + ONE;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    full_d  = full_q;
    valve_d = valve_q;
    conv_d  = conv_q;
    ppb_d   = ppb_q;
    tgt_d   = tgt_q;
    pill_d  = pill_q;
    bot_d   = bot_q;
    tmr_d   = tmr_q;

    case (state_q)
      S_CFG: begin
        if (bus.btn_ok) begin
          state_d = S_READY;
          set_d   = 1'b0;
        end else if (bus.btn_sel) begin
          set_d = ~set_q;
        end else if (bus.btn_inc ^ bus.btn_dec) begin
          // Simultaneous inc and dec cancel out (XOR above).
          if (!set_q) begin
            if (bus.btn_inc && ppb_q < PILL_MAX) ppb_d = ppb_q + ONE;
            if (bus.btn_dec && ppb_q > ONE)      ppb_d = ppb_q - ONE;
          end else begin
            if (bus.btn_inc && tgt_q < BOT_MAX)  tgt_d = tgt_q + ONE;
            if (bus.btn_dec && tgt_q > ONE)      tgt_d = tgt_q - ONE;
          end
        end
      end

      S_READY: begin
        if (bus.btn_start) begin
          state_d = S_FILL;
          set_d   = 1'b0;
          valve_d = 1'b1;
          pill_d  = '0;
          bot_d   = '0;
        end else if (bus.btn_sel || bus.btn_stop) begin
          state_d = S_CFG;
          set_d   = 1'b0;
        end
      end

      S_FILL: begin
        if (bus.btn_stop) begin
          state_d = S_READY;
          valve_d = 1'b0;
          conv_d  = 1'b0;
        end else if (bus.pill_pulse) begin
          if (pill_inc == ppb_q) begin
            valve_d = 1'b0;
            bot_d   = bot_inc;
            if (bot_inc == tgt_q) begin
              state_d = S_DONE;
              full_d  = 1'b1;
              pill_d  = pill_inc;
            end else begin
              state_d = S_MOVE;
              set_d   = 1'b1;
              pill_d  = '0;
              conv_d  = 1'b1;
              tmr_d   = TMR_LOAD;
            end
          end else begin
            pill_d = pill_inc;
          end
        end
      end

      S_MOVE: begin
        // Timer counts CONV_CYCLES-1 down to 0; the cycle spent at 0 is the
        // last conveyor cycle.
        if (bus.btn_stop) begin
          state_d = S_READY;
          set_d   = 1'b0;
          valve_d = 1'b0;
          conv_d  = 1'b0;
        end else if (tmr_q == '0) begin
          state_d = S_FILL;
          set_d   = 1'b0;
          conv_d  = 1'b0;
          valve_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_DONE: begin
        if (bus.btn_ok) begin
          state_d = S_READY;
          full_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_CFG;
        set_d   = 1'b0;
        full_d  = 1'b0;
        valve_d = 1'b0;
        conv_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_CFG;
      set_q   <= 1'b0;
      full_q  <= 1'b0;
      valve_q <= 1'b0;
      conv_q  <= 1'b0;
      ppb_q   <= ONE;
      tgt_q   <= ONE;
      pill_q  <= '0;
      bot_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      full_q  <= full_d;
      valve_q <= valve_d;
      conv_q  <= conv_d;
      ppb_q   <= ppb_d;
      tgt_q   <= tgt_d;
      pill_q  <= pill_d;
      bot_q   <= bot_d;
      tmr_q   <= tmr_d;
    end
  end

`ifdef BOTTLE_SPILL_CNT_EN
  logic [CNT_W-1:0] spill_q;

  // Clear on a run start takes precedence over a coincident stray pill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      spill_q <= '0;
    end else if (state_q == S_READY && bus.btn_start) begin
      spill_q <= '0;
    end else if (bus.pill_pulse && !valve_q && spill_q != '1) begin
      spill_q <= spill_q + ONE;
    end
  end

  assign bus.spill_cnt = spill_q;
`endif

  assign bus.EN_work          = state_q[2];
  assign bus.EN_set           = state_q[1];
  assign bus.SET              = set_q;
  assign bus.allFull          = full_q;
  assign bus.valve_open       = valve_q;
  assign bus.conveyor_on      = conv_q;
  assign bus.pills_per_bottle = ppb_q;
  assign bus.bottle_target    = tgt_q;
  assign bus.pill_cnt         = pill_q;
  assign bus.bottle_cnt       = bot_q;

endmodule

// File: tb/tb_bottle_ctrl.sv
// Directed self-checking bench for bottle_ctrl (CNT_W=8, MAX_PILLS=50,
// MAX_BOTTLES=99, CONV_CYCLES=4).
module tb_bottle_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  bottle_ctrl_if #(.CNT_W(8)) bus ();

  bottle_ctrl #(
    .CNT_W      (8),
    .MAX_PILLS  (50),
    .MAX_BOTTLES(99),
    .CONV_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    bus.btn_sel    = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_dec    = 1'b0;
    bus.btn_ok     = 1'b0;
    bus.btn_start  = 1'b0;
    bus.btn_stop   = 1'b0;
    bus.pill_pulse = 1'b0;
  endtask

  // Apply the currently driven inputs for one clock edge, then release them.
  task automatic tick();
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mode();
    return {29'd0, bus.EN_work, bus.EN_set, bus.SET};
  endfunction

  initial begin
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    check("rst_mode", mode(), 3'b000);
    check("rst_full", bus.allFull, 0);
    check("rst_valve", bus.valve_open, 0);
    check("rst_conv", bus.conveyor_on, 0);
    check("rst_ppb", bus.pills_per_bottle, 1);
    check("rst_tgt", bus.bottle_target, 1);
    check("rst_pill", bus.pill_cnt, 0);
    check("rst_bot", bus.bottle_cnt, 0);
`ifdef BOTTLE_SPILL_CNT_EN
    check("rst_spill", bus.spill_cnt, 0);
`endif

    // Configuration: 3x inc, sel, 1x inc
    for (int i = 0; i < 3; i++) begin bus.btn_inc = 1'b1; tick(); end
    bus.btn_sel = 1'b1; tick();
    bus.btn_inc = 1'b1; tick();
    check("cfg_ppb4", bus.pills_per_bottle, 4);
    check("cfg_tgt2", bus.bottle_target, 2);
    check("cfg_mode_set1", mode(), 3'b001);
    bus.btn_ok = 1'b1; tick();
    check("ok_ready", mode(), 3'b010);

    // Back to CFG via stop, tune pills to 2
    bus.btn_stop = 1'b1; tick();
    check("stop_to_cfg", mode(), 3'b000);
    bus.btn_dec = 1'b1; tick();
    bus.btn_dec = 1'b1; tick();
    check("dec_ppb2", bus.pills_per_bottle, 2);
    bus.btn_inc = 1'b1; bus.btn_dec = 1'b1; tick();
    check("incdec_same", bus.pills_per_bottle, 2);
    bus.btn_ok = 1'b1; bus.btn_sel = 1'b1; tick();
    check("ok_over_sel", mode(), 3'b010);

    // Run: 2 pills / 2 bottles
    bus.btn_start = 1'b1; tick();
    check("start_mode", mode(), 3'b100);
    check("start_valve", bus.valve_open, 1);
    bus.pill_pulse = 1'b1; tick();
    check("fill_pill1", bus.pill_cnt, 1);
    bus.pill_pulse = 1'b1; tick();
    check("move_mode", mode(), 3'b101);
    check("move_conv", bus.conveyor_on, 1);
    check("move_valve", bus.valve_open, 0);
    check("move_pill0", bus.pill_cnt, 0);
    check("move_bot1", bus.bottle_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) bus.pill_pulse = 1'b1;
      tick();
      check("move_conv_hold", bus.conveyor_on, 1);
      check("move_mode_hold", mode(), 3'b101);
      check("move_pill_ignored", bus.pill_cnt, 0);
    end
    tick();
    check("refill_mode", mode(), 3'b100);
    check("refill_conv_off", bus.conveyor_on, 0);
    check("refill_valve", bus.valve_open, 1);
`ifdef BOTTLE_SPILL_CNT_EN
    check("spill_move", bus.spill_cnt, 1);
`endif
    bus.pill_pulse = 1'b1; tick();
    bus.pill_pulse = 1'b1; tick();
    check("done_mode", mode(), 3'b110);
    check("done_full", bus.allFull, 1);
    check("done_pill", bus.pill_cnt, 2);
    check("done_bot", bus.bottle_cnt, 2);
    check("done_valve", bus.valve_open, 0);
    check("done_conv", bus.conveyor_on, 0);

    // DONE ignores everything except ok
    bus.btn_start = 1'b1; bus.btn_sel = 1'b1; bus.btn_inc = 1'b1; bus.btn_stop = 1'b1; tick();
    check("done_ignore_mode", mode(), 3'b110);
    check("done_ignore_ppb", bus.pills_per_bottle, 2);
    bus.btn_ok = 1'b1; tick();
    check("ack_mode", mode(), 3'b010);
    check("ack_full", bus.allFull, 0);
    check("ack_bot_hold", bus.bottle_cnt, 2);

    // Stop together with a pill pulse during FILL
    bus.btn_start = 1'b1; tick();
    check("restart_pill", bus.pill_cnt, 0);
    check("restart_bot", bus.bottle_cnt, 0);
`ifdef BOTTLE_SPILL_CNT_EN
    check("spill_cleared", bus.spill_cnt, 0);
`endif
    bus.pill_pulse = 1'b1; tick();
    bus.btn_stop = 1'b1; bus.pill_pulse = 1'b1; tick();
    check("stop_mode", mode(), 3'b010);
    check("stop_pill_hold", bus.pill_cnt, 1);
    check("stop_valve", bus.valve_open, 0);
    bus.btn_start = 1'b1; tick();
    check("start2_pill", bus.pill_cnt, 0);
    check("start2_bot", bus.bottle_cnt, 0);
    check("start2_valve", bus.valve_open, 1);

    // Reset mid-MOVE
    bus.pill_pulse = 1'b1; tick();
    bus.pill_pulse = 1'b1; tick();
    tick();
    check("pre_rst_move", mode(), 3'b101);
    RST = 1'b1; tick();
    RST = 1'b0;
    check("mrst_mode", mode(), 3'b000);
    check("mrst_conv", bus.conveyor_on, 0);
    check("mrst_valve", bus.valve_open, 0);
    check("mrst_full", bus.allFull, 0);
    check("mrst_ppb", bus.pills_per_bottle, 1);
    check("mrst_tgt", bus.bottle_target, 1);
    check("mrst_pill", bus.pill_cnt, 0);
    check("mrst_bot", bus.bottle_cnt, 0);

    // Saturation limits
    bus.btn_dec = 1'b1; tick();
    check("ppb_floor", bus.pills_per_bottle, 1);
    for (int i = 0; i < 60; i++) begin bus.btn_inc = 1'b1; tick(); end
    check("ppb_ceiling", bus.pills_per_bottle, 50);
    bus.btn_inc = 1'b1; bus.btn_dec = 1'b1; tick();
    check("ppb_incdec", bus.pills_per_bottle, 50);
    bus.btn_sel = 1'b1; tick();
    bus.btn_dec = 1'b1; tick();
    check("tgt_floor", bus.bottle_target, 1);
    for (int i = 0; i < 120; i++) begin bus.btn_inc = 1'b1; tick(); end
    check("tgt_ceiling", bus.bottle_target, 99);
    check("tgt_ppb_untouched", bus.pills_per_bottle, 50);

    // READY: start beats stop
    bus.btn_ok = 1'b1; tick();
    bus.btn_start = 1'b1; bus.btn_stop = 1'b1; tick();
    check("start_over_stop", mode(), 3'b100);
    bus.btn_stop = 1'b1; tick();
    check("fill_stop", mode(), 3'b010);
    bus.btn_sel = 1'b1; tick();
    check("ready_sel_cfg", mode(), 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bottle_ctrl.md
Name: bottle_ctrl

Overview:
- Master sequencer for the bottle-filling station.
- Owns the operating-mode state machine and drives the mode signals EN_work / EN_set / SET / allFull consumed by the indicator-light block.
- Holds the user-configured pills-per-bottle and bottle-target values.
- Counts pills and bottles, and drives the fill valve and the conveyor.

Parameters:
- CNT_W, 8, width of all count/config registers.
- MAX_PILLS, 50, upper saturation limit for pills-per-bottle setting.
- MAX_BOTTLES, 99, upper saturation limit for bottle-target setting.
- CONV_CYCLES, 4, clock cycles the conveyor runs per bottle change (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- btn_sel  input  1  one-cycle pulse (debounced upstream); toggles which setting is edited.
- btn_inc  input  1  one-cycle pulse; increment selected setting.
- btn_dec  input  1  one-cycle pulse; decrement selected setting.
- btn_ok  input  1  one-cycle pulse; confirm / acknowledge.
- btn_start  input  1  one-cycle pulse; start a run.
- btn_stop  input  1  one-cycle pulse; abort a run.
- pill_pulse  input  1  one-cycle pulse per pill passing the sensor.
- EN_work  output  1  mode bit.
- EN_set  output  1  mode bit.
- SET  output  1  sub-mode bit.
- allFull  output  1  batch complete.
- valve_open  output  1  fill valve drive.
- conveyor_on  output  1  conveyor drive.
- pills_per_bottle  output  CNT_W  current setting.
- bottle_target  output  CNT_W  current setting.
- pill_cnt  output  CNT_W  pills in current bottle.
- bottle_cnt  output  CNT_W  bottles completed this run.

Behaviour:
- All outputs are registered; an output changes on the clock edge where its state transition is taken, i.e. it is visible in the cycle after the triggering input.
- Reset values:
  - state=CFG, SET=0, allFull=0, valve_open=0, conveyor_on=0.
  - pills_per_bottle=1, bottle_target=1, pill_cnt=0, bottle_cnt=0, conveyor timer=0.
- Mode encoding (EN_work, EN_set, SET):
  - CFG: 0,0,sel.
  - READY: 0,1,0.
  - FILL: 1,0,0.
  - MOVE: 1,0,1.
  - DONE: 1,1,0.
- CFG:
  - Input priority: btn_ok > btn_sel > inc/dec.
  - btn_ok → READY.
  - btn_sel toggles SET (0 = edit pills_per_bottle, 1 = edit bottle_target).
  - btn_inc increments the selected value, saturating at MAX_PILLS / MAX_BOTTLES.
  - btn_dec decrements the selected value, saturating at 1.
  - btn_inc and btn_dec in the same cycle → no change.
- READY:
  - btn_start → FILL; clears pill_cnt and bottle_cnt; valve_open=1.
  - btn_sel or btn_stop → CFG with SET=0.
  - btn_start wins if simultaneous with either.
- FILL: valve_open=1; each pill_pulse increments pill_cnt. On the pulse where pill_cnt+1 == pills_per_bottle:
  - valve_open=0.
  - bottle_cnt increments.
  - If bottle_cnt+1 == bottle_target → DONE, allFull=1, pill_cnt holds final value.
  - Otherwise → MOVE, pill_cnt=0, conveyor_on=1, timer loaded with CONV_CYCLES-1.
- MOVE:
  - conveyor_on=1 for exactly CONV_CYCLES cycles.
  - Timer decrements each cycle; when the timer is 0 → FILL, conveyor_on=0, valve_open=1.
  - pill_pulse is ignored (no count change).
- btn_stop in FILL or MOVE:
  - → READY, valve_open=0, conveyor_on=0.
  - Counts hold their values until the next btn_start.
  - btn_stop takes priority over a simultaneous pill_pulse or timer expiry.
- DONE:
  - allFull=1, valve and conveyor off, counts hold.
  - btn_ok → READY with allFull=0.
  - All other buttons ignored.
- Settings are never modified outside CFG; btn_inc/btn_dec/btn_sel are ignored in FILL, MOVE and DONE.
- Counter widths: pill_cnt and bottle_cnt never exceed their settings, so no wrap is possible.
- RST asserted in any state, including mid-fill, forces the reset values on the next edge. Settings are reset too.

Optional Feature:
- Macro: BOTTLE_SPILL_CNT_EN.
- Defined:
  - Adds output spill_cnt [CNT_W] (reset 0).
  - spill_cnt increments on every pill_pulse arriving while valve_open=0 (MOVE, READY, DONE, CFG), saturating at all-ones.
  - Cleared on btn_start from READY.
- Not defined: the port and its logic are absent; such pulses are silently ignored.

Test Plan:
- Reset, then btn_inc×3, btn_sel, btn_inc×1 → pills_per_bottle=4, bottle_target=2, SET=1; btn_ok → mode 0,1,0.
- Config 2 pills / 2 bottles, btn_start, 2 pill_pulse → MOVE with conveyor_on high exactly 4 cycles (CONV_CYCLES=4), then FILL; 2 more pulses → DONE, allFull=1, bottle_cnt=2, pill_cnt=2.
- btn_dec at pills_per_bottle=1 → stays 1; btn_inc 60 times → saturates at 50; btn_inc+btn_dec same cycle → unchanged.
- During FILL with pill_cnt=1, assert btn_stop and pill_pulse together → READY, pill_cnt=1, valve_open=0; btn_start → counts cleared to 0.
- pill_pulse during MOVE → pill_cnt unchanged; with BOTTLE_SPILL_CNT_EN, spill_cnt=1.
- RST asserted mid-MOVE → next cycle CFG, all outputs at reset values, conveyor_on=0.
